sram_frame_reader: RTL
======================

// Module: sram_frame_reader
// PURPOSE
//  Read-side counterpart of the SoC SRAM writer: software draws 16-bit pixels into SRAM over
//  the sram_wire bus; this block reads them back sequentially into a small FIFO for the VGA
//  pixel pipeline. SRAM ownership is shared with the SoC writer through a req/gnt arbiter.
//  One frame = FRAME_WORDS words from BASE_ADDR, restarted by frame_start each vsync.
// PARAMETERS
//  BASE_ADDR    20'h00000  first SRAM word address of the frame buffer
//  FRAME_WORDS  307200     words per frame (640x480); must be <= 2^20 - BASE_ADDR
//  FIFO_DEPTH   16         pixel FIFO entries; power of 2, >= 4
//  READ_WAIT    1          cycles the address/OE_N are held before DQ is sampled (>= 1)
// PORTS
//  clk_clk        in   1   system clock, 50 MHz
//  reset_reset_n  in   1   reset: asynchronous, active-low
//  frame_start    in   1   1-cycle pulse; restart frame at BASE_ADDR
//  bus_req        out  1   request SRAM ownership
//  bus_gnt        in   1   SRAM ownership granted; may drop at any cycle
//  sram_ADDR      out  20  SRAM word address
//  sram_DQ_in     in   16  SRAM read data (tristate resolved at top level)
//  sram_CE_N      out  1   chip enable, active-low
//  sram_OE_N      out  1   output enable, active-low
//  sram_WE_N      out  1   write enable, constant 1 (never writes)
//  sram_LB_N      out  1   lower byte enable, active-low
//  sram_UB_N      out  1   upper byte enable, active-low
//  pix_valid      out  1   FIFO not empty
//  pix_ready      in   1   consumer pops one pixel when pix_valid && pix_ready
//  pix_data       out  16  FIFO head word (0 when empty)
//  frame_done     out  1   high once all FRAME_WORDS words pushed; cleared by frame_start
//  underflow      out  1   sticky: pix_ready seen while FIFO empty; cleared by frame_start
// BEHAVIOUR
//  - Reset: bus_req=0, sram_ADDR=0, CE_N/OE_N/WE_N/LB_N/UB_N=1, pix_valid=0, pix_data=0,
//    frame_done=0, underflow=0, FIFO empty, state IDLE, word counter 0. Reset mid-read
//    releases the bus immediately (asynchronous).
//  - States: IDLE -> REQ -> READ -> (REQ | DONE). DONE -> REQ only via frame_start.
//    IDLE/DONE: bus_req=0, all SRAM strobes high.
//    REQ: bus_req=1; when bus_gnt=1 and FIFO count < FIFO_DEPTH -> READ.
//    READ: bus_req=1; sram_ADDR=BASE_ADDR+word_cnt, CE_N=OE_N=LB_N=UB_N=0 for READ_WAIT+1
//    cycles; DQ sampled on the last edge and pushed; word_cnt++. Then: word_cnt==FRAME_WORDS
//    -> DONE (frame_done=1); else if gnt=1 and count < FIFO_DEPTH -> next word back-to-back
//    (strobes stay low); else -> REQ (strobes high, bus_req held).
//  - Latency (READ_WAIT=1): gnt sampled high at edge k -> strobes low in cycle k+1 ->
//    DQ pushed at edge k+2 -> pix_valid=1 in cycle k+3. Sustained rate 1 word / 2 cycles.
//  - Full: a word is started only when count < FIFO_DEPTH; pops during the word only free
//    space, so a push never hits a full FIFO. Reader stalls in REQ while full.
//  - gnt drop mid-word: word aborted (not pushed, word_cnt unchanged), strobes high in the
//    next cycle, state -> REQ; the same address is re-read after re-grant.
//  - Empty: pix_valid=0, pix_data=0; pix_ready while empty sets underflow, no pop.
//  - Simultaneous push and pop: both take effect; count unchanged. Push into empty with
//    pix_ready: no pop that cycle (pix_valid was 0).
//  - frame_start (any state, including mid-word): FIFO flushed, word_cnt=0, frame_done=0,
//    underflow=0, aborted word discarded, next state REQ; takes priority over a same-cycle push.
//  - Widths: word_cnt 20 bits; sram_ADDR = BASE_ADDR + word_cnt, no wrap beyond FRAME_WORDS.
// STRUCTURE
//  - final385_pkg: SRAM_AW=20, SRAM_DW=16, default FRAME_WORDS/BASE_ADDR, reader_state_t
//    enum {IDLE, REQ, READ, DONE}.
//  - Sub-module pixel_fifo (synchronous FIFO, FIFO_DEPTH x 16, push/pop/flush, count,
//    empty, full; pop head combinational); reader FSM + address counter in this file.
// TESTING
//  - Reset then frame_start, gnt=1, SRAM model data=addr[15:0], pix_ready=1, FRAME_WORDS=8
//    -> pix_data sequence 0..7, frame_done=1 after 8th push, bus_req=0, underflow=1 only
//    for pops attempted before first data.
//  - pix_ready=0, gnt=1 -> exactly 16 words pushed, strobes high, bus_req=1; one pop -> one
//    more word read at next address (16'h0010).
//  - Drop gnt during READ_WAIT cycle of word 5 -> word not pushed, strobes high next cycle;
//    re-grant -> address 5 re-read, output stream still 0,1,2,3,4,5,...
//  - frame_start asserted after 3 words pushed -> FIFO empty next cycle, next read at
//    BASE_ADDR, underflow and frame_done cleared.
//  - Assert reset_reset_n=0 while strobes low -> CE_N/OE_N=1 and bus_req=0 without a clock
//    edge; sram_WE_N stays 1 throughout every test.
//  - READ_WAIT=3 build -> strobes held 4 cycles per word, DQ sampled only on 4th edge
//    (model changes DQ earlier to prove it).

Source files
------------

// File: rtl/final385_pkg.sv
// Shared widths, defaults and state type for the SRAM frame reader.
package final385_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  localparam int                 DEFAULT_FRAME_WORDS = 307200;
  localparam logic [SRAM_AW-1:0] DEFAULT_BASE_ADDR   = 20'h00000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    READ,
    DONE
  } reader_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO: push/pop/flush, combinational head, zero head when empty.
module pixel_fifo
  import final385_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [SRAM_DW-1:0]       push_data,
  input  logic                     pop,
  output logic [SRAM_DW-1:0]       head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SRAM_DW-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array is written on every accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a flush empties the FIFO and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_frame_reader.sv
// Reads one frame of 16-bit pixels from shared SRAM into a small FIFO for the VGA pipeline.
module sram_frame_reader
  import final385_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int                 FRAME_WORDS = DEFAULT_FRAME_WORDS,
  parameter int                 FIFO_DEPTH  = 16,
  parameter int                 READ_WAIT   = 1
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               frame_start,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic [SRAM_AW-1:0] sram_ADDR,
  input  logic [SRAM_DW-1:0] sram_DQ_in,
  output logic               sram_CE_N,
  output logic               sram_OE_N,
  output logic               sram_WE_N,
  output logic               sram_LB_N,
  output logic               sram_UB_N,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [SRAM_DW-1:0] pix_data,
  output logic               frame_done,
  output logic               underflow
);

  localparam int                 CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int                 WW        = $clog2(READ_WAIT + 1);
  localparam logic [WW-1:0]      WAIT_LAST = WW'(READ_WAIT);
  localparam logic [SRAM_AW-1:0] LAST_WORD = SRAM_AW'(FRAME_WORDS - 1);

  reader_state_t      state;
  logic [SRAM_AW-1:0] word_cnt;
  logic [WW-1:0]      wait_cnt;
  logic               strobe_n;

  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;
  logic               fifo_push;
  logic               word_last_edge;
  logic               room_after_push;

  // All four active-low strobes move together; the reader never writes.
  assign sram_CE_N = strobe_n;
  assign sram_OE_N = strobe_n;
  assign sram_LB_N = strobe_n;
  assign sram_UB_N = strobe_n;
  assign sram_WE_N = 1'b1;

  assign pix_valid = !fifo_empty;
  assign fifo_pop  = pix_ready && !fifo_empty;

  // The word completes on the edge that ends its final hold cycle, provided we still own the bus.
  assign word_last_edge = (state == READ) && bus_gnt && (wait_cnt == WAIT_LAST);
  assign fifo_push      = word_last_edge && !frame_start;

  // A back-to-back word may start only if the FIFO will still have a free slot after this push.
  assign room_after_push = fifo_pop || (fifo_count < CW'(FIFO_DEPTH - 1));

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .flush    (frame_start),
    .push     (fifo_push),
    .push_data(sram_DQ_in),
    .pop      (fifo_pop),
    .head     (pix_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Reader FSM with address counter and registered bus/strobe outputs; frame_start overrides everything.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      wait_cnt   <= '0;
      bus_req    <= 1'b0;
      strobe_n   <= 1'b1;
      sram_ADDR  <= '0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      state      <= REQ;
      word_cnt   <= '0;
      wait_cnt   <= '0;
      bus_req    <= 1'b1;
      strobe_n   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_req  <= 1'b0;
          strobe_n <= 1'b1;
        end
        REQ: begin
          bus_req  <= 1'b1;
          strobe_n <= 1'b1;
          if (bus_gnt && !fifo_full) begin
            state     <= READ;
            sram_ADDR <= BASE_ADDR + word_cnt;
            strobe_n  <= 1'b0;
            wait_cnt  <= '0;
          end
        end
        READ: begin
          if (!bus_gnt) begin
            state    <= REQ;
            strobe_n <= 1'b1;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            word_cnt <= word_cnt + 20'd1;
            wait_cnt <= '0;
            if (word_cnt == LAST_WORD) begin
              state      <= DONE;
              bus_req    <= 1'b0;
              strobe_n   <= 1'b1;
              frame_done <= 1'b1;
            end else if (room_after_push) begin
              sram_ADDR <= BASE_ADDR + word_cnt + 20'd1;
            end else begin
              state    <= REQ;
              strobe_n <= 1'b1;
            end
          end
        end
        DONE: begin
          bus_req  <= 1'b0;
          strobe_n <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          bus_req  <= 1'b0;
          strobe_n <= 1'b1;
        end
      endcase
    end
  end

  // Sticky underflow flag: consumer asked for a pixel while none was available.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      underflow <= 1'b0;
    end else if (frame_start) begin
      underflow <= 1'b0;
    end else if (pix_ready && fifo_empty) begin
      underflow <= 1'b1;
    end
  end

endmodule
